// File: rtl/serdes_pkg.sv
// serdes_pkg: shared types, frame constants and the frame builder for the
// transmit-side byte framer.
// Optional feature macro: PARITY_EN (frame bit 9 carries even parity of the
// data byte; otherwise bit 9 is a second stop bit).
package serdes_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int         BYTE_W    = 8;
   localparam int         FRAME_W   = BYTE_W + 3;
   localparam logic       START_BIT = 1'b0;
   localparam logic       STOP_BIT  = 1'b1;
   localparam logic [3:0] LAST_BIT  = 4'd10;

   // Even parity: XOR of all data bits, so data plus parity has an even count of ones.
   function automatic logic even_parity(input logic [BYTE_W-1:0] data);
      return ^data;
   endfunction

   // Frame layout, LSB sent first: {stop, parity-or-stop, data[7:0], start}.
   function automatic logic [FRAME_W-1:0] build_frame(input logic [BYTE_W-1:0] data);
      logic w_bit9;
`ifdef PARITY_EN
      w_bit9 = even_parity(data);
`else
      w_bit9 = STOP_BIT;
`endif
      return {STOP_BIT, w_bit9, data, START_BIT};
   endfunction

endpackage

// File: rtl/serdes_sync_fifo.sv
// serdes_sync_fifo: small synchronous byte buffer. Full blocks pushes even when
// a pop happens in the same cycle, so there is no bypass path from input to output.
module serdes_sync_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_push,
   input  logic [DATA_W-1:0]             i_data,
   input  logic                          i_pop,
   output logic [DATA_W-1:0]             o_data,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [$clog2(FIFO_DEPTH):0]   o_count
);

   localparam int             AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);

   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              w_push;
   logic              w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == {(AW+1){1'b0}});
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // Storage write; contents are don't-care until a push makes them valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally since depth is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_count  <= {(AW+1){1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/serdes_tx_framer.sv
// serdes_tx_framer: buffers producer bytes, requests the link with data_en,
// latches an 11-bit frame on ser_en and shifts it out LSB-first while load_en
// is held. A window that closes early raises frame_err and drops the byte.
// Optional feature macro: PARITY_EN (see serdes_pkg::build_frame).
module serdes_tx_framer
   import serdes_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic [DATA_W-1:0]             in_data,
   output logic                          in_ready,
   input  logic                          bus_free,
   input  logic                          ser_en,
   input  logic                          load_en,
   output logic                          data_en,
   output logic                          tx_bit,
   output logic                          frame_done,
   output logic                          frame_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [FRAME_W-1:0]  r_shreg;
   logic [3:0]          r_bit_cnt;
   logic                r_frame_err;
   logic                w_pop;
   logic                w_shift;
   logic                w_abort;
   logic                w_full;
   logic                w_empty;
   logic                w_tx_bit;
   logic [DATA_W-1:0]   w_head;

   assign in_ready   = !w_full;
   assign data_en    = (r_state == REQ);
   assign frame_done = (r_state == DONE);
   assign frame_err  = r_frame_err;
   assign tx_bit     = w_tx_bit;

   serdes_sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (in_valid && in_ready),
      .i_data  (in_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count)
   );

   // Next-state decode plus the pop/shift/abort strobes for the datapath.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_shift     = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty && bus_free) begin
               w_state_nxt = REQ;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         REQ: begin
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (ser_en && !w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = SHIFT;
            end else begin
               w_state_nxt = WAIT;
            end
         end
         SHIFT: begin
            if (load_en) begin
               w_shift = 1'b1;
               if (r_bit_cnt == LAST_BIT) begin
                  w_state_nxt = DONE;
               end else begin
                  w_state_nxt = SHIFT;
               end
            end else if (r_bit_cnt != 4'd0) begin
               w_abort     = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = SHIFT;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Serial line: frame LSB only while the shift window is open, otherwise idle high.
   always_comb begin
      w_tx_bit = 1'b1;
      if ((r_state == SHIFT) && load_en) begin
         w_tx_bit = r_shreg[0];
      end else begin
         w_tx_bit = 1'b1;
      end
   end

   // State register and the registered error pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_frame_err <= w_abort;
      end
   end

   // Frame shift register and bit counter; counter returns to 0 when a frame ends.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_shreg   <= {FRAME_W{1'b1}};
         r_bit_cnt <= 4'd0;
      end else if (w_pop) begin
         r_shreg   <= build_frame(w_head);
         r_bit_cnt <= 4'd0;
      end else if (w_shift) begin
         r_shreg   <= {1'b1, r_shreg[FRAME_W-1:1]};
         r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? 4'd0 : (r_bit_cnt + 4'd1);
      end else if (w_abort) begin
         r_bit_cnt <= 4'd0;
      end else begin
         r_bit_cnt <= r_bit_cnt;
      end
   end

endmodule

// File: tb/tb_serdes_tx_framer.sv
// tb_serdes_tx_framer: directed stimulus with a scoreboard. Stimulus queues the
// expected serial bits and the expected data_en/frame_done/frame_err events;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_serdes_tx_framer;

   localparam int EV_REQ  = 1;
   localparam int EV_DONE = 2;
   localparam int EV_ERR  = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       bus_free;
   logic       ser_en;
   logic       load_en;
   logic       data_en;
   logic       tx_bit;
   logic       frame_done;
   logic       frame_err;
   logic [2:0] fifo_count;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic exp_bits[$];
   int   exp_ev[$];

   always #5 clk = ~clk;

   serdes_tx_framer #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .bus_free   (bus_free),
      .ser_en     (ser_en),
      .load_en    (load_en),
      .data_en    (data_en),
      .tx_bit     (tx_bit),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .fifo_count (fifo_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent frame model: start 0, data LSB first, bit 9, stop 1.
   function automatic logic [10:0] exp_frame(input logic [7:0] d);
      logic b9;
`ifdef PARITY_EN
      b9 = ^d;
`else
      b9 = 1'b1;
`endif
      return {1'b1, b9, d, 1'b0};
   endfunction

   task automatic queue_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) exp_bits.push_back(f[i]);
   endtask

   // From IDLE with a non-empty FIFO and bus_free=1: REQ, WAIT, then ser_en pulse.
   task automatic handshake();
      exp_ev.push_back(EV_REQ);
      tick();
      tick();
      ser_en = 1'b1;
      tick();
      ser_en = 1'b0;
   endtask

   task automatic pop_ev(input int code, input string name);
      int e;
      n_cmp++;
      if (exp_ev.size() == 0) begin
         n_bad++;
         $display("FAIL %s_unexpected: got pulse, expected none (t=%0t)", name, $time);
      end else begin
         n_cmp--;
         e = exp_ev.pop_front();
         chk({name, "_event"}, code, e);
      end
   endtask

   // Monitor: compare every presented bit and event against the scoreboard queues.
   always @(negedge clk) begin
      if (load_en === 1'b1) begin
         if (exp_bits.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_bit_unexpected: got %0b with no bit expected (t=%0t)", tx_bit, $time);
         end else begin
            chk("tx_bit", tx_bit, exp_bits.pop_front());
         end
      end
      if (data_en === 1'b1)    pop_ev(EV_REQ, "data_en");
      if (frame_done === 1'b1) pop_ev(EV_DONE, "frame_done");
      if (frame_err === 1'b1)  pop_ev(EV_ERR, "frame_err");
   end

   initial begin
      logic [7:0]  bytes [5];
      logic [10:0] a5_frame;
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
`ifdef PARITY_EN
      a5_frame = 11'h54A;
`else
      a5_frame = 11'h74A;
`endif
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      bus_free = 1'b0; ser_en = 1'b0; load_en = 1'b0;

      // 1: reset
      tick(); tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_data_en", data_en, 0);
      chk("rst_tx_bit", tx_bit, 1);
      chk("rst_count", fifo_count, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_err", frame_err, 0);
      rst_n = 1'b1;
      tick();

      // 2: single 0xA5 frame
      bus_free = 1'b1;
      in_valid = 1'b1; in_data = 8'hA5;
      tick();
      in_valid = 1'b0;
      chk("t2_count_1", fifo_count, 1);
      handshake();
      chk("t2_count_0", fifo_count, 0);
      queue_bits(a5_frame, 11);
      exp_ev.push_back(EV_DONE);
      load_en = 1'b1;
      repeat (11) tick();
      load_en = 1'b0;
      chk("t2_done_state", frame_done, 1);
      tick();
      chk("t2_tx_idle", tx_bit, 1);

      // 3: fill with bus busy, fifth byte dropped
      bus_free = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = bytes[i];
         tick();
         if (i == 3) begin
            chk("t3_in_ready_full", in_ready, 0);
            chk("t3_count_4", fifo_count, 4);
         end
      end
      in_valid = 1'b0;
      chk("t3_count_after5", fifo_count, 4);
      repeat (3) tick();

      // 4: full FIFO, push and pop in the same cycle
      bus_free = 1'b1;
      exp_ev.push_back(EV_REQ);
      tick(); tick();
      ser_en = 1'b1; in_valid = 1'b1; in_data = 8'h66;
      chk("t4_in_ready_pop", in_ready, 0);
      tick();
      ser_en = 1'b0; in_valid = 1'b0; bus_free = 1'b0;
      chk("t4_count_3", fifo_count, 3);

      // 5: window closes after 5 bits of 0x11
      queue_bits(exp_frame(8'h11), 5);
      exp_ev.push_back(EV_ERR);
      load_en = 1'b1;
      repeat (5) tick();
      load_en = 1'b0;
      tick();
      chk("t5_tx_idle", tx_bit, 1);
      chk("t5_err_pulse", frame_err, 1);
      tick();
      chk("t5_err_cleared", frame_err, 0);
      chk("t5_count_3", fifo_count, 3);

      // 6: reset after 6 bits of 0x22 (0x11 was not resent)
      bus_free = 1'b1;
      handshake();
      bus_free = 1'b0;
      chk("t6_count_2", fifo_count, 2);
      queue_bits(exp_frame(8'h22), 6);
      load_en = 1'b1;
      repeat (6) tick();
      load_en = 1'b0; rst_n = 1'b0;
      tick();
      chk("t6_tx_idle", tx_bit, 1);
      chk("t6_count_0", fifo_count, 0);
      chk("t6_no_done", frame_done, 0);
      chk("t6_no_err", frame_err, 0);
      chk("t6_in_ready", in_ready, 1);
      rst_n = 1'b1;
      repeat (3) tick();

      // 7: fresh 0xA5 frame, explicit bit 9 check
      bus_free = 1'b1;
      in_valid = 1'b1; in_data = 8'hA5;
      tick();
      in_valid = 1'b0;
      handshake();
      queue_bits(a5_frame, 11);
      exp_ev.push_back(EV_DONE);
      for (int i = 0; i < 11; i++) begin
         load_en = 1'b1;
         if (i == 9) begin
            #1;
`ifdef PARITY_EN
            chk("t7_bit9", tx_bit, 0);
`else
            chk("t7_bit9", tx_bit, 1);
`endif
         end
         tick();
      end
      load_en = 1'b0;
      repeat (3) tick();

      chk("end_bits_drained", exp_bits.size(), 0);
      chk("end_events_drained", exp_ev.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
